// File: rtl/simplecpu_pkg.sv
// Shared definitions for the simplecpu_p core: opcodes, FSM states and
// instruction field positions of the fixed 16-bit encoding.
package simplecpu_pkg;

   localparam int INSTR_W = 16;
   localparam int FIELD_W = 4;
   localparam int K8_W    = 8;
   localparam int OP_LSB  = 12;
   localparam int RA_LSB  = 8;
   localparam int RB_LSB  = 4;
   localparam int RC_LSB  = 0;
   localparam int K8_LSB  = 0;

   typedef enum logic [3:0] {
      OP_LOAD  = 4'h0,
      OP_STORE = 4'h1,
      OP_ADD   = 4'h2,
      OP_LOADC = 4'h3,
      OP_JMPZ  = 4'h4,
      OP_SUB   = 4'h5,
      OP_HALT  = 4'hF
   } opcode_e;

   typedef enum logic [2:0] {
      S_INIT,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_LOAD_WB,
      S_STEP_WAIT,
      S_HALT
   } state_e;

   function automatic logic op_legal(input logic [3:0] op);
      case (op)
         OP_LOAD, OP_STORE, OP_ADD, OP_LOADC,
         OP_JMPZ, OP_SUB, OP_HALT: op_legal = 1'b1;
         default:                  op_legal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/simplecpu_rf.sv
// Register file: two combinational read ports, one synchronous write port.
// Latency: reads same cycle, writes visible after the clock edge.
// Backpressure: none; a write in the reset cycle is discarded.
module simplecpu_rf #(
   parameter int DATA_W = 16,
   parameter int NREGS  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [$clog2(NREGS)-1:0] rd0_addr,
   output logic [DATA_W-1:0]        rd0_data,
   input  logic [$clog2(NREGS)-1:0] rd1_addr,
   output logic [DATA_W-1:0]        rd1_data,
   input  logic                     we,
   input  logic [$clog2(NREGS)-1:0] waddr,
   input  logic [DATA_W-1:0]        wdata
);

   logic [DATA_W-1:0] regs [NREGS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   assign rd0_data = regs[rd0_addr];
   assign rd1_data = regs[rd1_addr];

endmodule

// File: rtl/simplecpu_p.sv
// Multi-cycle accumulator-free CPU with a single-step debug mode.
// Latency: 3 cycles per instruction, 4 for LOAD; HALT stops after decode.
// Backpressure: none; single-step mode parks in STEP_WAIT until dbg_step.
module simplecpu_p
   import simplecpu_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int NREGS  = 16,
   parameter int PC_W   = 10,
   parameter int DM_AW  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dbg_mode,
   input  logic              dbg_step,
   output logic [PC_W-1:0]   pc,
   output logic              imem_rd,
   input  logic [15:0]       imem_data,
   output logic [DM_AW-1:0]  dmem_addr,
   output logic              dmem_rd,
   output logic              dmem_wr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic              halted,
   output logic              illegal
);

   localparam int RI_W = $clog2(NREGS);

   state_e             state;
   logic [INSTR_W-1:0] ir;
   logic [3:0]         op;
   logic [RI_W-1:0]    ra, rb, rc, rd0_addr;
   logic [K8_W-1:0]    k8;
   logic [DATA_W-1:0]  rd0, rd1, wdata, k8_sext;
   logic [PC_W-1:0]    jmp_tgt;
   logic               we;

   assign op       = ir[OP_LSB +: FIELD_W];
   assign ra       = ir[RA_LSB +: RI_W];
   assign rb       = ir[RB_LSB +: RI_W];
   assign rc       = ir[RC_LSB +: RI_W];
   assign k8       = ir[K8_LSB +: K8_W];
   assign k8_sext  = DATA_W'($signed(k8));
   // pc already points past the JMPZ, so back off by one to get a JMPZ-relative target
   assign jmp_tgt  = pc + PC_W'($signed(k8)) - PC_W'(1);

   // Port 0 serves rb for ALU ops and ra for STORE/JMPZ; port 1 always serves rc.
   assign rd0_addr   = (op == OP_ADD || op == OP_SUB) ? rb : ra;
   assign dmem_addr  = ir[K8_LSB +: DM_AW];
   assign dmem_wdata = rd0;

   always_comb begin
      we    = 1'b0;
      wdata = k8_sext;
      if (state == S_LOAD_WB) begin
         we    = 1'b1;
         wdata = dmem_rdata;
      end else if (state == S_EXEC) begin
         case (op)
            OP_ADD:   begin we = 1'b1; wdata = rd0 + rd1; end
            OP_SUB:   begin we = 1'b1; wdata = rd0 - rd1; end
            OP_LOADC: begin we = 1'b1; wdata = k8_sext;   end
            default:  ;
         endcase
      end
   end

   simplecpu_rf #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS)
   ) u_rf (
      .clk      (clk),
      .rst      (rst),
      .rd0_addr (rd0_addr),
      .rd0_data (rd0),
      .rd1_addr (rc),
      .rd1_data (rd1),
      .we       (we),
      .waddr    (ra),
      .wdata    (wdata)
   );

   // Strobes are registered on entry to the state that owns them.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_INIT;
         pc      <= '0;
         ir      <= '0;
         imem_rd <= 1'b0;
         dmem_rd <= 1'b0;
         dmem_wr <= 1'b0;
         halted  <= 1'b0;
         illegal <= 1'b0;
      end else begin
         case (state)
            S_INIT: begin
               state   <= dbg_mode ? S_STEP_WAIT : S_FETCH;
               imem_rd <= !dbg_mode;
            end
            S_FETCH: begin
               ir      <= imem_data;
               pc      <= pc + PC_W'(1);
               imem_rd <= 1'b0;
               state   <= S_DECODE;
            end
            S_DECODE: begin
               if (op == OP_HALT || !op_legal(op)) begin
                  state  <= S_HALT;
                  halted <= 1'b1;
                  if (!op_legal(op)) illegal <= 1'b1;
               end else begin
                  state   <= S_EXEC;
                  dmem_rd <= (op == OP_LOAD);
                  dmem_wr <= (op == OP_STORE);
               end
            end
            S_EXEC: begin
               dmem_rd <= 1'b0;
               dmem_wr <= 1'b0;
               if (op == OP_LOAD) begin
                  state <= S_LOAD_WB;
               end else begin
                  if (op == OP_JMPZ && rd0 == '0) pc <= jmp_tgt;
                  state   <= dbg_mode ? S_STEP_WAIT : S_FETCH;
                  imem_rd <= !dbg_mode;
               end
            end
            S_LOAD_WB: begin
               state   <= dbg_mode ? S_STEP_WAIT : S_FETCH;
               imem_rd <= !dbg_mode;
            end
            S_STEP_WAIT: begin
               if (dbg_step) begin
                  state   <= S_FETCH;
                  imem_rd <= 1'b1;
               end
            end
            S_HALT:  ;
            default: state <= S_INIT;
         endcase
      end
   end

endmodule
